// File: rtl/otter_wb_arbiter_pkg.sv
// Shared types, requester indices and the wrap-safe age compare for the write-back arbiter.
package otter_wb_pkg;

  localparam int SEQ_W_DEF = 6;
  // Tags are carried zero-extended to this width so one compare function serves any SEQ_W.
  localparam int SEQ_W_MAX = 16;

  localparam int REQ_ALU0 = 0;
  localparam int REQ_ALU1 = 1;
  localparam int REQ_LD   = 2;

  typedef struct packed {
    logic [4:0]           rd;
    logic [31:0]          data;
    logic [SEQ_W_MAX-1:0] seq;
  } wb_req_t;

  // a is older than b when the top tag bit of (a - b) mod 2^w is set.
  function automatic logic seq_older(input logic [SEQ_W_MAX-1:0] a,
                                     input logic [SEQ_W_MAX-1:0] b,
                                     input int                   w);
    logic [SEQ_W_MAX-1:0] diff;
    logic [SEQ_W_MAX-1:0] mask;
    diff = a - b;
    mask = SEQ_W_MAX'(1) << (w - 1);
    return |(diff & mask);
  endfunction

endpackage

// File: rtl/otter_wb_arbiter_if.sv
// Requester-side bundle: per-requester valid/rd/data/seq in, combinational ready out.
interface otter_wb_arbiter_if
  import otter_wb_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int SEQ_W = SEQ_W_DEF
);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*5-1:0]     req_rd;
  logic [N_REQ*32-1:0]    req_data;
  logic [N_REQ*SEQ_W-1:0] req_seq;
  logic [N_REQ-1:0]       req_ready;

  modport master (output req_valid, req_rd, req_data, req_seq, input req_ready);
  modport slave  (input req_valid, req_rd, req_data, req_seq, output req_ready);

endinterface

// File: rtl/otter_wb_arbiter_pick2.sv
// Combinational oldest/second-oldest picker; zero latency, no state.
module otter_wb_pick2
  import otter_wb_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int SEQ_W = SEQ_W_DEF
) (
  input  logic [N_REQ-1:0]           elig,
  input  logic [N_REQ*SEQ_W_MAX-1:0] tags,
  output logic [N_REQ-1:0]           g1,
  output logic [N_REQ-1:0]           g2
);

  logic [2:0] rank [N_REQ];

  // Rank = number of eligible peers older than me; equal tags fall back to lower index.
  always_comb begin
    g1 = '0;
    g2 = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rank[i] = 3'd0;
      for (int j = 0; j < N_REQ; j++) begin
        if (j != i && elig[j]) begin
          if (tags[j*SEQ_W_MAX +: SEQ_W_MAX] == tags[i*SEQ_W_MAX +: SEQ_W_MAX]) begin
            if (j < i) rank[i] = rank[i] + 3'd1;
          end else if (seq_older(tags[j*SEQ_W_MAX +: SEQ_W_MAX],
                                 tags[i*SEQ_W_MAX +: SEQ_W_MAX], SEQ_W)) begin
            rank[i] = rank[i] + 3'd1;
          end
        end
      end
      g1[i] = elig[i] && (rank[i] == 3'd0);
      g2[i] = elig[i] && (rank[i] == 3'd1);
    end
  end

endmodule

// File: rtl/otter_wb_arbiter.sv
// Two-port write-back arbiter: grants the two oldest results, outputs registered one cycle later.
// Ungranted requesters see ready=0 and must hold; optional WB_FWD_EN adds a 4-lane bypass.
module otter_wb_arbiter
  import otter_wb_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int SEQ_W = SEQ_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  otter_wb_arbiter_if.slave req,
  output logic              RegWrite,
  output logic [4:0]        WriteReg,
  output logic [31:0]       WriteData,
  output logic              RegWrite_2,
  output logic [4:0]        WriteReg_2,
  output logic [31:0]       WriteData_2,
  output logic [CNT_W-1:0]  wb_stall_cnt
`ifdef WB_FWD_EN
  ,
  input  logic [4*5-1:0]    fwd_rs,
  output logic [3:0]        fwd_hit,
  output logic [4*32-1:0]   fwd_data
`endif
);

  wb_req_t                    req_s [N_REQ];
  logic [N_REQ-1:0]           elig;
  logic [N_REQ-1:0]           x0_req;
  logic [N_REQ-1:0]           g1;
  logic [N_REQ-1:0]           g2;
  logic [N_REQ*SEQ_W_MAX-1:0] tags;
  logic [4:0]                 g1_rd;
  logic [4:0]                 g2_rd;
  logic [31:0]                g1_data;
  logic [31:0]                g2_data;
  logic                       stall;

  always_comb begin
    elig   = '0;
    x0_req = '0;
    tags   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_s[i].rd   = req.req_rd[i*5 +: 5];
      req_s[i].data = req.req_data[i*32 +: 32];
      req_s[i].seq  = SEQ_W_MAX'(req.req_seq[i*SEQ_W +: SEQ_W]);
      // Writes to x0 are acknowledged but never take a port.
      elig[i]   = req.req_valid[i] && (req_s[i].rd != 5'd0);
      x0_req[i] = req.req_valid[i] && (req_s[i].rd == 5'd0);
      tags[i*SEQ_W_MAX +: SEQ_W_MAX] = req_s[i].seq;
    end
  end

  otter_wb_pick2 #(
    .N_REQ (N_REQ),
    .SEQ_W (SEQ_W)
  ) u_pick2 (
    .elig (elig),
    .tags (tags),
    .g1   (g1),
    .g2   (g2)
  );

  always_comb begin
    g1_rd   = '0;
    g1_data = '0;
    g2_rd   = '0;
    g2_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (g1[i]) begin
        g1_rd   = req_s[i].rd;
        g1_data = req_s[i].data;
      end
      if (g2[i]) begin
        g2_rd   = req_s[i].rd;
        g2_data = req_s[i].data;
      end
    end
  end

  assign req.req_ready = reset ? '0 : (g1 | g2 | x0_req);
  assign stall         = |(elig & ~(g1 | g2));

  always_ff @(posedge clock) begin
    if (reset) begin
      RegWrite     <= 1'b0;
      WriteReg     <= '0;
      WriteData    <= '0;
      RegWrite_2   <= 1'b0;
      WriteReg_2   <= '0;
      WriteData_2  <= '0;
      wb_stall_cnt <= '0;
    end else begin
      RegWrite   <= |g1;
      RegWrite_2 <= |g2;
      if (|g1) begin
        WriteReg  <= g1_rd;
        WriteData <= g1_data;
      end
      if (|g2) begin
        WriteReg_2  <= g2_rd;
        WriteData_2 <= g2_data;
      end
      if (stall && (wb_stall_cnt != '1)) wb_stall_cnt <= wb_stall_cnt + 1'b1;
    end
  end

`ifdef WB_FWD_EN
  // Port 2 wins on a double match, mirroring the register file's write priority.
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    for (int k = 0; k < 4; k++) begin
      if (fwd_rs[k*5 +: 5] != 5'd0) begin
        if (RegWrite_2 && (WriteReg_2 == fwd_rs[k*5 +: 5])) begin
          fwd_hit[k]          = 1'b1;
          fwd_data[k*32 +: 32] = WriteData_2;
        end else if (RegWrite && (WriteReg == fwd_rs[k*5 +: 5])) begin
          fwd_hit[k]          = 1'b1;
          fwd_data[k*32 +: 32] = WriteData;
        end
      end
    end
  end
`endif

endmodule
